// File: rtl/td4_fetch_if.sv
// td4_fetch_if
// Groups the two handshakes around the TD4 fetch stage:
//   - program load port: prog_data/prog_valid/prog_last in, prog_ready out
//   - instruction port : instr_valid/opcode/immediate/pc_out out, instr_ready in
// Modports:
//   master - the side that loads programs and consumes instructions
//   slave  - the fetch stage itself
interface td4_fetch_if;
    logic [7:0] prog_data;
    logic       prog_valid;
    logic       prog_ready;
    logic       prog_last;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic [3:0] pc_out;

    modport master (
        output prog_data, prog_valid, prog_last, instr_ready,
        input  prog_ready, instr_valid, opcode, immediate, pc_out
    );

    modport slave (
        input  prog_data, prog_valid, prog_last, instr_ready,
        output prog_ready, instr_valid, opcode, immediate, pc_out
    );
endinterface

// File: rtl/td4_fetch.sv
// td4_fetch
// Instruction fetch stage in front of the TD4 CPU datapath. Holds a
// 16 x 8-bit program memory that is filled over a byte-wide valid/ready
// port, then presents opcode/immediate/pc to the CPU and owns the program
// counter, including JMP and JNC (jump when carry is clear) redirection.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - td4_fetch_if.slave (program load + instruction handshakes)
//   run       - leave LOAD without writing, keeping memory contents
//   reload    - return from RUN to LOAD (memory retained)
//   carry_in  - CPU carry flag, sampled on the advance cycle
//   step      - only with TD4_FETCH_STEP_EN: gates instr_valid in RUN so
//               the program can be single-stepped on a board
//   loading   - high while in LOAD
//
// Optional feature macro: TD4_FETCH_STEP_EN (adds the step input).
module td4_fetch #(
    parameter logic [7:0] MEM_INIT = 8'h00,
    parameter logic [3:0] JMP_OP   = 4'b1111,
    parameter logic [3:0] JNC_OP   = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    td4_fetch_if.slave bus,
    input  logic       run,
    input  logic       reload,
    input  logic       carry_in,
`ifdef TD4_FETCH_STEP_EN
    input  logic       step,
`endif
    output logic       loading
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_PRIME,
        S_RUN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] load_addr_q, load_addr_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];

    logic       fetched_valid;
    logic       accept;
    logic       advance;
    logic [3:0] next_pc;

    // Outputs are driven straight from registers so the CPU sees a clean
    // instruction word for the whole cycle.
    assign fetched_valid  = (state_q == S_RUN);
    assign bus.prog_ready = (state_q == S_LOAD);
    assign loading        = (state_q == S_LOAD);
    assign bus.opcode     = instr_q[7:4];
    assign bus.immediate  = instr_q[3:0];
    assign bus.pc_out     = pc_q;

`ifdef TD4_FETCH_STEP_EN
    assign bus.instr_valid = fetched_valid & step;
`else
    assign bus.instr_valid = fetched_valid;
`endif

    assign accept  = bus.prog_valid & bus.prog_ready;
    assign advance = bus.instr_valid & bus.instr_ready;

    // Branch resolution works on the currently presented instruction, so the
    // target instruction can be loaded on the same edge with no bubble.
    always_comb begin
        next_pc = pc_q + 4'd1;
        if (instr_q[7:4] == JMP_OP) begin
            next_pc = instr_q[3:0];
        end else if ((instr_q[7:4] == JNC_OP) && !carry_in) begin
            next_pc = instr_q[3:0];
        end
    end

    // Next-state logic. reload is checked before advance so a simultaneous
    // advance is dropped and the pc ends at 0.
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        mem_d       = mem_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    mem_d[load_addr_q] = bus.prog_data;
                    load_addr_d        = load_addr_q + 4'd1;
                    if (bus.prog_last || (load_addr_q == 4'd15) || run) begin
                        state_d     = S_PRIME;
                        load_addr_d = 4'd0;
                    end
                end else if (run) begin
                    state_d     = S_PRIME;
                    load_addr_d = 4'd0;
                end
            end
            S_PRIME: begin
                instr_d = mem_q[0];
                pc_d    = 4'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (reload) begin
                    state_d     = S_LOAD;
                    pc_d        = 4'd0;
                    load_addr_d = 4'd0;
                end else if (advance) begin
                    pc_d    = next_pc;
                    instr_d = mem_q[next_pc];
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and memory registers; reset restores every entry to MEM_INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            load_addr_q <= 4'd0;
            pc_q        <= 4'd0;
            instr_q     <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= MEM_INIT;
            end
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_td4_fetch.sv
// tb_td4_fetch
// Self-checking bench for td4_fetch. A behavioural model (program array plus
// a program counter advanced by the JMP/JNC/increment rules) predicts every
// presented instruction; inputs are driven and outputs sampled 1 ns after
// the rising clock edge.
module tb_td4_fetch;

    logic clk;
    logic rst;
    logic run;
    logic reload;
    logic carry_in;
    logic loading;
`ifdef TD4_FETCH_STEP_EN
    logic step;
`endif

    td4_fetch_if bus ();

    td4_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .run      (run),
        .reload   (reload),
        .carry_in (carry_in),
`ifdef TD4_FETCH_STEP_EN
        .step     (step),
`endif
        .loading  (loading)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    logic [7:0] model_mem [16];
    logic [3:0] mpc;
    int         vec_count;
    int         miscompares;

    // Reference rule for the next program counter
    function automatic logic [3:0] model_next(input logic [3:0] pc,
                                              input logic [7:0] ins,
                                              input logic c);
        int op;
        int imm;
        int p;
        op  = int'(ins) / 16;
        imm = int'(ins) % 16;
        p   = int'(pc);
        if (op == 15) return 4'(imm);
        if (op == 14 && !c) return 4'(imm);
        return 4'((p + 1) % 16);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [7:0] obs,
                            input logic [7:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [7:0] pd,
                                 input logic pl, input logic r,
                                 input logic rl, input logic ir,
                                 input logic c);
        bus.prog_valid  = pv;
        bus.prog_data   = pd;
        bus.prog_last   = pl;
        run             = r;
        reload          = rl;
        bus.instr_ready = ir;
        carry_in        = c;
    endtask

    task automatic checkOutput(input string tag, input logic exp_loading,
                               input logic exp_valid, input logic [3:0] exp_pc,
                               input logic [7:0] exp_instr,
                               input logic check_instr);
        check_eq({tag, ".loading"}, 8'(loading), 8'(exp_loading));
        check_eq({tag, ".prog_ready"}, 8'(bus.prog_ready), 8'(exp_loading));
        check_eq({tag, ".instr_valid"}, 8'(bus.instr_valid), 8'(exp_valid));
        check_eq({tag, ".pc_out"}, 8'(bus.pc_out), 8'(exp_pc));
        if (check_instr) begin
            check_eq({tag, ".opcode"}, 8'(bus.opcode), 8'(exp_instr[7:4]));
            check_eq({tag, ".immediate"}, 8'(bus.immediate), 8'(exp_instr[3:0]));
        end
    endtask

    // One RUN cycle with the given ready/carry; the model advances only
    // when the CPU accepts the instruction.
    task automatic step_once(input string tag, input logic ir, input logic c);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, ir, c);
        if (ir) mpc = model_next(mpc, model_mem[mpc], c);
        tick();
        checkOutput(tag, 1'b0, 1'b1, mpc, model_mem[mpc], 1'b1);
    endtask

    task automatic run_cycles(input string tag, input int n,
                              input logic rand_ready);
        for (int k = 0; k < n; k++) begin
            logic ir;
            logic c;
            ir = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            c  = 1'($urandom_range(0, 1));
            step_once(tag, ir, c);
        end
    endtask

    // Advance with ready=1 until the model pc reaches target (bounded)
    task automatic advance_to(input string tag, input logic [3:0] target);
        for (int k = 0; k < 40 && mpc != target; k++) begin
            step_once(tag, 1'b1, 1'($urandom_range(0, 1)));
        end
        check_eq({tag, ".reached"}, 8'(bus.pc_out), 8'(target));
    endtask

    // First RUN cycle after PRIME presents mem[0] at pc 0
    task automatic enter_run(input string tag);
        checkOutput({tag, ".prime"}, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        mpc = 4'd0;
        checkOutput({tag, ".first"}, 1'b0, 1'b1, 4'd0, model_mem[0], 1'b1);
    endtask

    task automatic load_prog(input string tag, input logic [7:0] bytes[$],
                             input logic use_last, input logic use_run);
        for (int i = 0; i < bytes.size(); i++) begin
            logic fin;
            fin = (i == bytes.size() - 1);
            applyStimulus(1'b1, bytes[i], use_last & fin, use_run & fin,
                          1'b0, 1'b1, 1'b0);
            tick();
            model_mem[i] = bytes[i];
            if (!fin) checkOutput({tag, ".load"}, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
        end
        enter_run(tag);
    endtask

    task automatic run_only(input string tag);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        enter_run(tag);
    endtask

    task automatic do_reload(input string tag, input logic ir);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, ir, 1'b0);
        tick();
        mpc = 4'd0;
        checkOutput(tag, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] prog[$];
        int         len;

        vec_count   = 0;
        miscompares = 0;
`ifdef TD4_FETCH_STEP_EN
        step = 1'b1;
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        mpc = 4'd0;

        // Reset state
        rst = 1'b1;
        #12;
        checkOutput("reset", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_reset", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1);

        // Three-byte program ending in JMP 1: loops (1,0,5),(2,F,1)
        $display("[TB] three-byte JMP loop");
        prog = '{8'h31, 8'h05, 8'hF1};
        load_prog("jmp_loop", prog, 1'b1, 1'b0);
        run_cycles("jmp_loop", 6, 1'b0);

        // Full 16-byte load without prog_last, non-jump opcodes only
        $display("[TB] sixteen-byte auto exit and pc wrap");
        do_reload("reload1", 1'b1);
        prog = {};
        for (int i = 0; i < 16; i++) begin
            prog.push_back({4'($urandom_range(0, 13)), 4'($urandom_range(0, 15))});
        end
        load_prog("auto_exit", prog, 1'b0, 1'b0);
        run_cycles("wrap", 18, 1'b0);

        // Stall at pc 3 for four cycles, then release
        $display("[TB] stall at pc 3");
        advance_to("to_pc3", 4'd3);
        for (int k = 0; k < 4; k++) begin
            step_once("stall", 1'b0, 1'($urandom_range(0, 1)));
        end
        step_once("release", 1'b1, 1'b0);
        check_eq("release.pc4", 8'(bus.pc_out), 8'd4);
        run_cycles("rand_ready", 20, 1'b1);

        // reload together with an advance at pc 6, memory kept
        $display("[TB] reload beats advance");
        advance_to("to_pc6", 4'd6);
        do_reload("reload_adv", 1'b1);
        run_only("rerun");
        run_cycles("intact", 16, 1'b0);

        // JNC 7 at address 0 with carry set, then with carry clear
        $display("[TB] JNC carry handling");
        do_reload("reload2", 1'b0);
        prog = '{8'hE7};
        load_prog("jnc", prog, 1'b1, 1'b0);
        step_once("jnc_carry1", 1'b1, 1'b1);
        check_eq("jnc_carry1.pc", 8'(bus.pc_out), 8'd1);
        do_reload("reload3", 1'b1);
        run_only("jnc_rerun");
        step_once("jnc_carry0", 1'b1, 1'b0);
        check_eq("jnc_carry0.pc", 8'(bus.pc_out), 8'd7);

        // Random program, final byte accepted together with run
        $display("[TB] random program");
        do_reload("reload4", 1'b1);
        len = $urandom_range(3, 15);
        prog = {};
        for (int i = 0; i < len; i++) prog.push_back(8'($urandom_range(0, 255)));
        load_prog("rand_prog", prog, 1'b0, 1'b1);
        run_cycles("rand_run", 40, 1'b1);

        // Reset in the middle of a load
        $display("[TB] reset mid-load");
        do_reload("reload5", 1'b0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("after_reset", 1'b1, 1'b0, 4'd0, 8'h00, 1'b1);
        run_only("init_mem");
        run_cycles("init_mem", 17, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/td4_fetch.md
Name: td4_fetch

Overview:
Instruction fetch stage that sits directly upstream of the TD4 CPU datapath.
- Holds a 16-entry x 8-bit program memory.
- Memory is loaded over a byte-wide valid/ready port.
- In RUN, presents opcode/immediate to the CPU and owns the program counter, including JMP/JNC redirection using the CPU carry flag.

Parameters:
MEM_INIT, 8'h00, value every program memory entry takes on reset
JMP_OP, 4'b1111, opcode of unconditional jump (JMP Im)
JNC_OP, 4'b1110, opcode of jump-if-no-carry (JNC Im)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset (single clock; active-high, so no _n suffix)
prog_data  input  8  program byte, [7:4]=opcode, [3:0]=immediate
prog_valid  input  1  prog_data valid
prog_ready  output  1  high in LOAD state only
prog_last  input  1  qualifies the accepted byte as the final one
run  input  1  leave LOAD without writing, keep current memory contents
reload  input  1  return from RUN to LOAD
carry_in  input  1  CPU carry flag, sampled on the advance cycle
instr_ready  input  1  CPU accepts the presented instruction
instr_valid  output  1  opcode/immediate/pc_out valid
opcode  output  4  presented opcode
immediate  output  4  presented immediate
pc_out  output  4  address of presented instruction
loading  output  1  high in LOAD state

Behaviour:
- Reset (asynchronous, active-high), all values hold while rst=1:
  - state=LOAD, load_addr=0, pc=0.
  - opcode=0, immediate=0, pc_out=0, instr_valid=0.
  - Every memory entry = MEM_INIT.
  - Reset mid-load or mid-run aborts immediately with no partial effects.
- States: LOAD, PRIME, RUN.
- LOAD:
  - prog_ready=1, loading=1, instr_valid=0.
  - Write when prog_valid & prog_ready: mem[load_addr] <= prog_data, then load_addr+1.
  - Go to PRIME when the accepted byte has prog_last=1, or was written at load_addr=15.
  - run=1 with no accepted byte: go to PRIME, memory unchanged.
  - run and an accepted byte in the same cycle: the write happens, then go to PRIME.
  - On exit, load_addr resets to 0.
- PRIME:
  - Lasts one cycle.
  - Output register <= mem[0], pc=0, go to RUN.
  - instr_valid rises on the first RUN cycle, so fetch latency is 1 cycle after leaving LOAD.
- RUN:
  - Outputs come from registers: opcode=instr[7:4], immediate=instr[3:0], pc_out=pc, instr_valid=1.
  - Advance when instr_valid & instr_ready. On an advance:
    - next_pc = immediate if opcode==JMP_OP.
    - next_pc = immediate if opcode==JNC_OP and carry_in==0.
    - Otherwise next_pc = pc+1 mod 16 (15 wraps to 0).
    - pc <= next_pc; output register <= mem[next_pc] in the same edge, so back-to-back instructions issue with zero bubbles.
  - No advance (instr_ready=0): all outputs hold stable.
  - Jump to self (e.g. pc=5, JMP 5) re-presents the same instruction every advance; no special case.
- reload in RUN:
  - Next state LOAD; instr_valid=0 next cycle; pc=0, load_addr=0.
  - Memory is retained.
  - reload beats a simultaneous advance: pc ends at 0 and the advance is discarded.
  - reload is ignored in LOAD and PRIME.
- Memory:
  - Written only in LOAD.
  - Read is asynchronous into the output register.
  - No read-during-write hazard is possible.

Optional Feature:
TD4_FETCH_STEP_EN
- Defined:
  - Adds input port step (1 bit).
  - In RUN, instr_valid = fetched_valid & step (combinational gate), so an advance requires step=1.
  - Holding step=0 freezes pc and outputs, giving a single-step clock for board debug.
  - step has no effect in LOAD/PRIME.
- Undefined: no step port; instr_valid = fetched_valid.

Test Plan:
- Reset, then load 3 bytes 8'h31, 8'h05, 8'hF1 (last on the 3rd) with instr_ready=1 → mem[0..2] written, then PRIME, then instr_valid=1.
  - Presented sequence (pc,opcode,imm): (0,3,1), (1,0,5), (2,F,1), (1,0,5), (2,F,1)… (JMP loop).
- Program with 8'hE7 at addr 0, carry_in=1 on the advance → next pc=1; repeat after reload+run with carry_in=0 → next pc=7.
- Load 16 bytes without prog_last → auto-exit after addr 15; a run of 16 non-jump instructions wraps pc 15→0.
- Hold instr_ready=0 for 4 cycles mid-run at pc=3 → outputs frozen at pc 3; release → pc 4 next cycle.
- Assert reload together with an advance at pc=6 → LOAD, instr_valid=0, pc=0, memory intact; run → first presented is mem[0].
- Assert rst mid-load after 2 bytes → all entries read MEM_INIT, state LOAD, prog_ready=1 after release.
